// File: rtl/alu_sequencer_pkg.sv
// Shared types for the accumulator sequencer: ALU opcode mnemonics, FSM states, instruction field positions.
package alu_sequencer_pkg;

    typedef enum logic [8:0] {
        OP_NOP    = 9'd0,
        OP_MOVE   = 9'd1,
        OP_ASSIGN = 9'd2,
        OP_LOAD   = 9'd3,
        OP_STORE  = 9'd4,
        OP_ADD    = 9'd5,
        OP_LSL    = 9'd6,
        OP_LSR    = 9'd7,
        OP_B      = 9'd8,
        OP_BEQ    = 9'd9,
        OP_BLT    = 9'd10,
        OP_BGE    = 9'd11,
        OP_BGT    = 9'd12,
        OP_ORR    = 9'd13,
        OP_AND    = 9'd14,
        OP_SUB    = 9'd15
    } op_mne;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} seq_state_t;

    localparam int         IMM_BIT  = 8;
    localparam int         OPC_MSB  = 7;
    localparam int         OPC_LSB  = 4;
    localparam logic [3:0] HALT_OPC = 4'hF;

    // The halt opcode has no ALU operation of its own, so it decodes to OP_NOP.
    function automatic op_mne opc_to_op(input logic [3:0] opc);
        case (opc)
            4'h0:    return OP_MOVE;
            4'h1:    return OP_ASSIGN;
            4'h2:    return OP_LOAD;
            4'h3:    return OP_STORE;
            4'h4:    return OP_ADD;
            4'h5:    return OP_LSL;
            4'h6:    return OP_LSR;
            4'h7:    return OP_B;
            4'h8:    return OP_BEQ;
            4'h9:    return OP_BLT;
            4'hA:    return OP_BGE;
            4'hB:    return OP_BGT;
            4'hC:    return OP_ORR;
            4'hD:    return OP_AND;
            4'hE:    return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Sequencer <-> ROM/ALU/regfile bundle; master = sequencer, slave = datapath side.
// CYCLE_CNT_EN adds the CYCLES counter and ZFLAG export.
interface alu_sequencer_if import alu_sequencer_pkg::*; #(parameter int PC_W = 10);
    logic            START;
    logic [8:0]      INSTR;
    logic [PC_W-1:0] PC;
    op_mne           OP;
    logic            SET;
    logic [7:0]      SETNUM;
    logic            SC_IN;
    logic            SC_OUT;
    logic            ZERO;
    logic            EQ;
    logic [3:0]      RADDR;
    logic            REG_WE;
    logic            MEM_WE;
    logic            DONE;
`ifdef CYCLE_CNT_EN
    logic [15:0]     CYCLES;
    logic            ZFLAG;

    modport master (input START, INSTR, SC_OUT, ZERO, EQ,
                    output PC, OP, SET, SETNUM, SC_IN, RADDR, REG_WE, MEM_WE, DONE, CYCLES, ZFLAG);
    modport slave  (output START, INSTR, SC_OUT, ZERO, EQ,
                    input PC, OP, SET, SETNUM, SC_IN, RADDR, REG_WE, MEM_WE, DONE, CYCLES, ZFLAG);
`else
    modport master (input START, INSTR, SC_OUT, ZERO, EQ,
                    output PC, OP, SET, SETNUM, SC_IN, RADDR, REG_WE, MEM_WE, DONE);
    modport slave  (output START, INSTR, SC_OUT, ZERO, EQ,
                    input PC, OP, SET, SETNUM, SC_IN, RADDR, REG_WE, MEM_WE, DONE);
`endif
endinterface

// File: rtl/alu_sequencer_pc_unit.sv
// Program counter: load START_PC, increment, or add a signed 4-bit offset, all modulo 2^PC_W.
// Updates on the clock edge after a request; load wins over branch, branch over increment.
module alu_sequencer_pc_unit #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            inc_i,
    input  logic            branch_i,
    input  logic [3:0]      offset_i,
    output logic [PC_W-1:0] pc_o
);
    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i)
            pc_d = START_PC;
        else if (branch_i)
            pc_d = pc_q + {{(PC_W-4){offset_i[3]}}, offset_i};
        else if (inc_i)
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= START_PC;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/alu_sequencer.sv
// Fetch/exec/writeback sequencer driving the accumulator ALU; 3 cycles per instruction, START ignored mid-instruction.
// CYCLE_CNT_EN adds a saturating busy-cycle counter (CYCLES) and the registered zero flag (ZFLAG).
module alu_sequencer import alu_sequencer_pkg::*; #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input logic              CLK,
    input logic              RESET,
    alu_sequencer_if.master  bus
);
    seq_state_t state_q, state_d;
    logic [8:0] ir_q;
    logic       c_q, c_d;
    logic       eq_q, sc_q, z_q;
    logic       pc_load, pc_inc, pc_branch;
    logic [PC_W-1:0] pc;
    op_mne      op, ir_op;
    logic       set, reg_we, mem_we;
    logic [7:0] setnum;
    logic       start_ok;

    assign start_ok = bus.START && ((state_q == IDLE) || (state_q == HALT));
    assign ir_op    = opc_to_op(ir_q[OPC_MSB:OPC_LSB]);

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_branch = 1'b0;
        op        = OP_NOP;
        set       = 1'b0;
        setnum    = 8'h00;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (start_ok) begin
                    state_d = FETCH;
                    pc_load = 1'b1;
                    c_d     = 1'b0;
                end
            end
            FETCH: state_d = EXEC;
            EXEC: begin
                state_d = WB;
                if (bus.INSTR[IMM_BIT]) begin
                    set    = 1'b1;
                    setnum = bus.INSTR[7:0];
                end else begin
                    op = opc_to_op(bus.INSTR[OPC_MSB:OPC_LSB]);
                end
            end
            WB: begin
                state_d = FETCH;
                if (ir_q[IMM_BIT]) begin
                    pc_inc = 1'b1;
                end else begin
                    case (ir_op)
                        OP_ASSIGN, OP_ORR, OP_AND: begin
                            reg_we = 1'b1;
                            pc_inc = 1'b1;
                        end
                        OP_ADD, OP_LSL, OP_LSR: begin
                            reg_we = 1'b1;
                            c_d    = sc_q;
                            pc_inc = 1'b1;
                        end
                        OP_SUB: begin
                            reg_we = 1'b1;
                            c_d    = 1'b0;
                            pc_inc = 1'b1;
                        end
                        OP_STORE: begin
                            mem_we = 1'b1;
                            pc_inc = 1'b1;
                        end
                        // The ALU has already folded the branch condition into EQ.
                        OP_B, OP_BEQ, OP_BLT, OP_BGE, OP_BGT: begin
                            pc_branch = eq_q;
                            pc_inc    = ~eq_q;
                        end
                        default: begin
                            if (ir_q[OPC_MSB:OPC_LSB] == HALT_OPC)
                                state_d = HALT;
                            else
                                pc_inc = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            c_q     <= 1'b0;
            ir_q    <= 9'h000;
            eq_q    <= 1'b0;
            sc_q    <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            if (state_q == EXEC) begin
                ir_q <= bus.INSTR;
                eq_q <= bus.EQ;
                sc_q <= bus.SC_OUT;
                z_q  <= bus.ZERO;
            end
        end
    end

    alu_sequencer_pc_unit #(.PC_W(PC_W), .START_PC(START_PC)) u_pc (
        .clk      (CLK),
        .rst      (RESET),
        .load_i   (pc_load),
        .inc_i    (pc_inc),
        .branch_i (pc_branch),
        .offset_i (ir_q[3:0]),
        .pc_o     (pc)
    );

    assign bus.PC     = pc;
    assign bus.OP     = op;
    assign bus.SET    = set;
    assign bus.SETNUM = setnum;
    assign bus.SC_IN  = c_q;
    assign bus.RADDR  = (state_q == EXEC) ? bus.INSTR[3:0] : ir_q[3:0];
    assign bus.REG_WE = reg_we;
    assign bus.MEM_WE = mem_we;
    assign bus.DONE   = (state_q == HALT);

`ifdef CYCLE_CNT_EN
    logic [15:0] cycles_q;

    always_ff @(posedge CLK) begin
        if (RESET || start_ok)
            cycles_q <= 16'h0000;
        else if ((state_q == FETCH || state_q == EXEC || state_q == WB) && cycles_q != 16'hFFFF)
            cycles_q <= cycles_q + 16'h0001;
    end

    assign bus.CYCLES = cycles_q;
    assign bus.ZFLAG  = z_q;
`else
    logic unused_z;
    assign unused_z = z_q;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: synchronous ROM model, flags driven per EXEC cycle.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] rom [0:1023];

    alu_sequencer_if #(.PC_W(10)) bus ();

    alu_sequencer #(.PC_W(10), .START_PC(10'd0)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk) bus.INSTR <= rom[bus.PC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered in FETCH; leaves the bench at the following FETCH (or HALT).
    task automatic do_instr(input logic [9:0] exp_pc, input logic eq, input logic sc);
        chk("fetch_pc", 32'(bus.PC), 32'(exp_pc));
        tick();
        bus.EQ     = eq;
        bus.SC_OUT = sc;
        tick();
        bus.EQ     = 1'b0;
        bus.SC_OUT = 1'b0;
        tick();
    endtask

    task automatic start_pulse();
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
        rom[0] = 9'h1A5;
        rom[1] = 9'h0F0;
        rst        = 1'b1;
        bus.START  = 1'b0;
        bus.SC_OUT = 1'b0;
        bus.ZERO   = 1'b0;
        bus.EQ     = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_pc", 32'(bus.PC), 0);
        chk("rst_done", 32'(bus.DONE), 0);
        chk("rst_regwe", 32'(bus.REG_WE), 0);
        chk("rst_memwe", 32'(bus.MEM_WE), 0);
        chk("rst_set", 32'(bus.SET), 0);
        chk("rst_op", 32'(bus.OP), 32'(OP_NOP));
        chk("rst_scin", 32'(bus.SC_IN), 0);
`ifdef CYCLE_CNT_EN
        chk("rst_cycles", 32'(bus.CYCLES), 0);
`endif
        rst = 1'b0;
        tick();

        // Immediate load then halt
        start_pulse();
        chk("t1_fetch_pc", 32'(bus.PC), 0);
        chk("t1_fetch_set", 32'(bus.SET), 0);
        tick();
        chk("t1_exec_set", 32'(bus.SET), 1);
        chk("t1_exec_setnum", 32'(bus.SETNUM), 32'h0A5);
        chk("t1_exec_op", 32'(bus.OP), 32'(OP_NOP));
        tick();
        chk("t1_wb_set", 32'(bus.SET), 0);
        chk("t1_wb_regwe", 32'(bus.REG_WE), 0);
        tick();
        chk("t1_pc1", 32'(bus.PC), 1);
        tick();
        chk("t1_halt_exec_op", 32'(bus.OP), 32'(OP_NOP));
        tick();
        chk("t1_wb_done", 32'(bus.DONE), 0);
        tick();
        chk("t1_done", 32'(bus.DONE), 1);

        // Carry from add feeds lsl; START clears carry
        rom[0] = 9'h041;
        rom[1] = 9'h052;
        rom[2] = 9'h0F0;
        start_pulse();
        chk("t2_scin0", 32'(bus.SC_IN), 0);
        tick();
        chk("t2_add_op", 32'(bus.OP), 32'(OP_ADD));
        chk("t2_add_raddr", 32'(bus.RADDR), 1);
        bus.SC_OUT = 1'b1;
        tick();
        bus.SC_OUT = 1'b0;
        chk("t2_add_regwe", 32'(bus.REG_WE), 1);
        tick();
        chk("t2_fetch_regwe", 32'(bus.REG_WE), 0);
        tick();
        chk("t2_lsl_op", 32'(bus.OP), 32'(OP_LSL));
        chk("t2_lsl_scin", 32'(bus.SC_IN), 1);
        chk("t2_exec_regwe", 32'(bus.REG_WE), 0);
        bus.SC_OUT = 1'b1;
        tick();
        bus.SC_OUT = 1'b0;
        chk("t2_lsl_regwe", 32'(bus.REG_WE), 1);
        tick();
        do_instr(10'd2, 1'b0, 1'b0);
        chk("t2_done", 32'(bus.DONE), 1);
        chk("t2_halt_scin", 32'(bus.SC_IN), 1);

        // sub clears carry; beq at 5 taken back to 3, then falls through to 6
        for (int i = 0; i < 8; i++) rom[i] = 9'h000;
        rom[0] = 9'h043;
        rom[1] = 9'h0E1;
        rom[5] = 9'h08E;
        rom[6] = 9'h0F0;
        start_pulse();
        chk("t3_start_clears_c", 32'(bus.SC_IN), 0);
        do_instr(10'd0, 1'b0, 1'b1);
        chk("t3_c_after_add", 32'(bus.SC_IN), 1);
        do_instr(10'd1, 1'b0, 1'b1);
        chk("t3_c_after_sub", 32'(bus.SC_IN), 0);
        do_instr(10'd2, 1'b0, 1'b0);
        do_instr(10'd3, 1'b0, 1'b0);
        do_instr(10'd4, 1'b0, 1'b0);
        do_instr(10'd5, 1'b1, 1'b0);
        do_instr(10'd3, 1'b0, 1'b0);
        do_instr(10'd4, 1'b0, 1'b0);
        do_instr(10'd5, 1'b0, 1'b0);
        do_instr(10'd6, 1'b0, 1'b0);
        chk("t3_done", 32'(bus.DONE), 1);

        // PC wrap both ways
        for (int i = 0; i < 8; i++) rom[i] = 9'h000;
        rom[0]    = 9'h07F;
        rom[1]    = 9'h0F0;
        rom[1023] = 9'h000;
        start_pulse();
        do_instr(10'd0, 1'b1, 1'b0);
        do_instr(10'd1023, 1'b0, 1'b0);
        do_instr(10'd0, 1'b0, 1'b0);
        do_instr(10'd1, 1'b0, 1'b0);
        chk("t4_done", 32'(bus.DONE), 1);

        // RESET during EXEC of a store
        rom[0] = 9'h043;
        rom[1] = 9'h035;
        start_pulse();
        do_instr(10'd0, 1'b0, 1'b1);
        chk("t5_c_set", 32'(bus.SC_IN), 1);
        tick();
        chk("t5_store_op", 32'(bus.OP), 32'(OP_STORE));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_memwe", 32'(bus.MEM_WE), 0);
        chk("t5_pc", 32'(bus.PC), 0);
        chk("t5_c", 32'(bus.SC_IN), 0);
        chk("t5_done", 32'(bus.DONE), 0);
        tick();
        tick();
        tick();
        chk("t5_idle_pc", 32'(bus.PC), 0);
        chk("t5_idle_op", 32'(bus.OP), 32'(OP_NOP));

        // Store strobe; START during WB ignored
        rom[0] = 9'h035;
        rom[1] = 9'h0F0;
        start_pulse();
        tick();
        chk("t6_exec_memwe", 32'(bus.MEM_WE), 0);
        tick();
        chk("t6_memwe", 32'(bus.MEM_WE), 1);
        chk("t6_raddr", 32'(bus.RADDR), 5);
        chk("t6_regwe", 32'(bus.REG_WE), 0);
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        chk("t6_pc_after_wb", 32'(bus.PC), 1);
        chk("t6_memwe_off", 32'(bus.MEM_WE), 0);
        tick();
        tick();
        tick();
        chk("t6_done", 32'(bus.DONE), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control sequencer for the CSE141L accumulator datapath. It fetches 9-bit instructions from the synchronous instruction ROM, decodes them, and drives the ALU's OP, SET, SETNUM and SC_IN inputs. It consumes the ALU's SC_OUT, ZERO and EQ flags to hold the carry and resolve branches. It owns the PC, register-file and memory write strobes, and the program DONE handshake.

Parameters:
PC_W, 10, PC and ROM address width
START_PC, 0, PC value loaded on RESET and on each accepted START

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
START  in  1  one-cycle pulse; begins execution at START_PC when IDLE or HALT
INSTR  in  9  ROM data; valid the cycle after PC is presented
PC  out  PC_W  instruction ROM address
OP  out  9  ALU opcode (op_mne encoding from definitions)
SET  out  1  ALU immediate-load strobe
SETNUM  out  8  ALU immediate value
SC_IN  out  1  carry/shift-in, driven from internal carry register C
SC_OUT  in  1  ALU carry/shift-out
ZERO  in  1  ALU zero flag
EQ  in  1  ALU compare flag
RADDR  out  4  register/memory index = INSTR[3:0]
REG_WE  out  1  register-file write strobe, one cycle
MEM_WE  out  1  data-memory write strobe, one cycle
DONE  out  1  high while in HALT

Behaviour:
- Reset: state IDLE, PC=START_PC, C=0, IR=0, OP=0, SET=0, SETNUM=0, REG_WE=0, MEM_WE=0, DONE=0. RESET overrides every other input, including mid-instruction.
- States:
  - IDLE: START goes to FETCH.
  - FETCH: PC is presented; next state is EXEC.
  - EXEC: IR<=INSTR at entry; OP/SET/SETNUM are driven for this one cycle; flags are sampled at the end of the cycle; next state is WB.
  - WB: PC update, C update, strobes; next state is FETCH, or HALT on a halt instruction.
  - HALT: DONE=1; START goes to FETCH with PC=START_PC and C=0.
- Timing: 3 cycles per instruction. START while in FETCH/EXEC/WB is ignored.
- Decode, INSTR[8]=1: immediate. SET=1 and SETNUM=INSTR[7:0] in EXEC; OP=0.
- Decode, INSTR[8]=0: opcode INSTR[7:4] maps to ALU ops:
  - 0 move, 1 assign, 2 load, 3 store
  - 4 add, 5 lsl, 6 lsr
  - 7 b, 8 beq, 9 blt, A bge, B bgt
  - C orr, D and, E sub
  - F halt; OP=0 in EXEC.
- Outputs outside EXEC: OP/SET/SETNUM are 0.
- WB strobes: REG_WE=1 for assign, add, lsl, lsr, orr, and, sub. MEM_WE=1 for store. No strobe for any other instruction.
- Carry: C<=SC_OUT (sampled in EXEC) for add, lsl, lsr. C<=0 for sub. All other instructions leave C unchanged. SC_IN=C at all times.
- Branch: b, beq, blt, bge and bgt are taken iff EQ=1 in EXEC. The ALU encodes the condition, so the sequencer does not re-evaluate it.
  - Taken: PC<=PC+sext(INSTR[3:0]), range -8..+7 relative to the branch's own PC.
  - Not taken: PC<=PC+1.
- PC arithmetic is modulo 2^PC_W: 1023+1 gives 0; a branch at 0 with offset -1 gives 1023.
- ZERO is registered into internal flag Z in EXEC and is exported only under the optional feature.

Optional Feature:
CYCLE_CNT_EN
- Defined: adds output CYCLES[15:0], cleared on RESET and on accepted START, incremented every cycle outside IDLE/HALT, saturating at 16'hFFFF. Also adds output ZFLAG = Z.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Decomposition:
- Package definitions (existing): reuse op_mne. Add typedef enum logic[2:0] seq_state_t {IDLE, FETCH, EXEC, WB, HALT} and localparams for the instruction fields: IMM_BIT=8, OPC_MSB=7, OPC_LSB=4, HALT_OPC=4'hF.
- Sub-module pc_unit: holds PC; inputs load/inc/branch/offset; performs the modulo add.

Test Plan:
- RESET=1 for 2 cycles, then START -> PC=0 in FETCH; DONE=0; all strobes 0.
- ROM[0]=9'h1A5 (SET 0xA5), ROM[1]=9'h0F0 (halt) -> SET=1 and SETNUM=0xA5 for exactly one EXEC cycle; DONE=1 after WB of PC 1.
- add with SC_OUT=1 in EXEC, then lsl -> SC_IN=1 during the lsl EXEC cycle; REG_WE pulses once per instruction.
- beq at PC=5 with INSTR[3:0]=4'hE and EQ=1 -> next FETCH PC=3. Same instruction with EQ=0 -> next FETCH PC=6.
- Branch at PC=0, offset 4'hF, EQ=1 -> PC=1023. Straight-line code at PC=1023 -> PC=0.
- RESET asserted during EXEC of a store -> no MEM_WE, state IDLE, PC=0, C=0. START during WB -> ignored; PC sequence unchanged.
